// File: rtl/exu_mdu_pkg.sv
// ---------------------------------------------------------------------------
// exu_mdu_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit:
//   funct3 encodings of the M-extension ops, the FSM state encoding and
//   small decode helpers used at issue time.
// ---------------------------------------------------------------------------
package exu_mdu_pkg;

    // M-extension funct3 encodings
    localparam logic [2:0] ZCRV_MDU_MUL    = 3'b000;
    localparam logic [2:0] ZCRV_MDU_MULH   = 3'b001;
    localparam logic [2:0] ZCRV_MDU_MULHSU = 3'b010;
    localparam logic [2:0] ZCRV_MDU_MULHU  = 3'b011;
    localparam logic [2:0] ZCRV_MDU_DIV    = 3'b100;
    localparam logic [2:0] ZCRV_MDU_DIVU   = 3'b101;
    localparam logic [2:0] ZCRV_MDU_REM    = 3'b110;
    localparam logic [2:0] ZCRV_MDU_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_CALC = 2'd1;
    localparam logic [1:0] MDU_DONE = 2'd2;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic mdu_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is a signed operand for MULH, MULHSU, DIV and REM.
    function automatic logic mdu_rs1_signed(input logic [2:0] f3);
        return (f3 == ZCRV_MDU_MULH) || (f3 == ZCRV_MDU_MULHSU) ||
               (f3 == ZCRV_MDU_DIV)  || (f3 == ZCRV_MDU_REM);
    endfunction

    // rs2 is a signed operand for MULH, DIV and REM.
    function automatic logic mdu_rs2_signed(input logic [2:0] f3);
        return (f3 == ZCRV_MDU_MULH) || (f3 == ZCRV_MDU_DIV) ||
               (f3 == ZCRV_MDU_REM);
    endfunction

endpackage

// File: rtl/exu_mdu_step.sv
// ---------------------------------------------------------------------------
// exu_mdu_step
//   One combinational iteration of the MDU datapath on unsigned magnitudes.
//   Multiply (shift-add): {hi,lo} is the product accumulator, lo starts as
//   the multiplier; add opb (multiplicand) into hi when lo[0] is set, then
//   shift the whole accumulator (with carry) right by one.
//   Divide (restoring): hi is the partial remainder, lo starts as the
//   dividend and fills with quotient bits; shift {hi,lo} left by one,
//   subtract opb (divisor) from hi when it fits.
//
//   is_div  in   1     select divide iteration (else multiply)
//   hi_i    in   XLEN  accumulator high half / partial remainder
//   lo_i    in   XLEN  accumulator low half / dividend-quotient register
//   opb     in   XLEN  multiplicand / divisor magnitude
//   hi_o    out  XLEN  next hi
//   lo_o    out  XLEN  next lo
// ---------------------------------------------------------------------------
module exu_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;

    always_comb begin
        mul_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb} : '0);

        // Remainder stays below the divisor, so after the subtraction it
        // fits in XLEN bits; the wrapped XLEN-bit difference is exact.
        div_shift = {hi_i, lo_i[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb) : div_shift[XLEN-1:0];

        if (is_div) begin
            hi_o = div_rem;
            lo_o = {lo_i[XLEN-2:0], div_ge};
        end else begin
            hi_o = mul_sum[XLEN:1];
            lo_o = {mul_sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exu_mdu.sv
// ---------------------------------------------------------------------------
// exu_mdu
//   Iterative RV32M multiply/divide execute unit. Accepts one M op via
//   valid/ready, iterates STEP bits per cycle for XLEN/STEP cycles on
//   operand magnitudes, fixes signs on entry to DONE and presents the rd
//   write-back value via valid/ready. Divide-by-zero and signed overflow
//   skip the iteration and complete the cycle after accept.
//
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      decode presents an M op
//   in_ready   out  1      unit can accept (IDLE only)
//   funct3     in   3      M-extension op select
//   rs1_data   in   XLEN   dividend / multiplicand
//   rs2_data   in   XLEN   divisor / multiplier
//   rd_in      in   REG_W  destination index, carried with the op
//   flush      in   1      kill the in-flight op
//   out_valid  out  1      result available
//   out_ready  in   1      write-back accepts result
//   result     out  XLEN   rd write-back value
//   rd_out     out  REG_W  destination of result
//   busy       out  1      op in CALC or DONE
// ---------------------------------------------------------------------------
module exu_mdu
    import exu_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEP  = 1,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [REG_W-1:0] rd_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [REG_W-1:0] rd_out,
    output logic             busy
);

    localparam int ITER  = XLEN / STEP;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [REG_W-1:0] rd_q;
    logic             neg_q;
    logic [XLEN-1:0]  opb_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  result_q;

    // ---------------- issue-side decode ----------------
    logic            div_op;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;
    logic            op_neg;

    always_comb begin
        div_op   = mdu_is_div(funct3);
        rs1_neg  = mdu_rs1_signed(funct3) & rs1_data[XLEN-1];
        rs2_neg  = mdu_rs2_signed(funct3) & rs2_data[XLEN-1];
        rs1_mag  = rs1_neg ? -rs1_data : rs1_data;
        rs2_mag  = rs2_neg ? -rs2_data : rs2_data;

        div_zero = div_op && (rs2_data == '0);
        div_ovf  = div_op && mdu_rs2_signed(funct3) &&
                   (rs1_data == MIN_NEG) && (rs2_data == '1);

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : rs1_data;
        end

        // Remainder follows the dividend; quotient and product follow the
        // XOR of the (signed-interpreted) operand signs.
        op_neg = (div_op && funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
    end

    // ---------------- iteration chain ----------------
    logic [XLEN-1:0] hi_c [STEP+1];
    logic [XLEN-1:0] lo_c [STEP+1];

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        exu_mdu_step #(
            .XLEN (XLEN)
        ) u_step (
            .is_div (f3_q[2]),
            .hi_i   (hi_c[g]),
            .lo_i   (lo_c[g]),
            .opb    (opb_q),
            .hi_o   (hi_c[g+1]),
            .lo_o   (lo_c[g+1])
        );
    end

    // ---------------- sign correction / result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod   = {hi_c[STEP], lo_c[STEP]};
        prod_s = neg_q ? -prod : prod;
        case (f3_q)
            ZCRV_MDU_MUL:    final_res = prod_s[XLEN-1:0];
            ZCRV_MDU_MULH,
            ZCRV_MDU_MULHSU,
            ZCRV_MDU_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            ZCRV_MDU_DIV,
            ZCRV_MDU_DIVU:   final_res = neg_q ? -lo_c[STEP] : lo_c[STEP];
            default:         final_res = neg_q ? -hi_c[STEP] : hi_c[STEP];
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MDU_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (in_valid) begin
                        f3_q <= funct3;
                        rd_q <= rd_in;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state    <= MDU_DONE;
                        end else begin
                            neg_q <= op_neg;
                            opb_q <= div_op ? rs2_mag : rs1_mag;
                            lo_q  <= div_op ? rs1_mag : rs2_mag;
                            hi_q  <= '0;
                            cnt   <= CNT_W'(ITER);
                            state <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    hi_q <= hi_c[STEP];
                    lo_q <= lo_c[STEP];
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_q <= final_res;
                        state    <= MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    if (out_ready) begin
                        state <= MDU_IDLE;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == MDU_IDLE);
    // A flush in DONE masks out_valid so a coincident out_ready is no handshake.
    assign out_valid = (state == MDU_DONE) && !flush;
    assign busy      = (state != MDU_IDLE);
    assign result    = result_q;
    assign rd_out    = rd_q;

endmodule

// File: tb/tb_exu_mdu.sv
// ---------------------------------------------------------------------------
// tb_exu_mdu
//   Self-checking bench for exu_mdu. Two units (STEP=1 and STEP=4) run the
//   same directed vector table and multi-cycle corner-case sequences.
// ---------------------------------------------------------------------------
module tb_exu_mdu;

    localparam int XLEN = 32;

    logic        clk;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [2:0]  funct3    [2];
    logic [31:0] rs1_data  [2];
    logic [31:0] rs2_data  [2];
    logic [4:0]  rd_in     [2];
    logic        flush     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic [4:0]  rd_out    [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exu_mdu #(
            .XLEN  (XLEN),
            .STEP  ((g == 0) ? 1 : 4),
            .REG_W (5)
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .funct3    (funct3[g]),
            .rs1_data  (rs1_data[g]),
            .rs2_data  (rs2_data[g]),
            .rd_in     (rd_in[g]),
            .flush     (flush[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result[g]),
            .rd_out    (rd_out[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    vec_t vec[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Present one op at a negedge; return #1 after the accept edge.
    task automatic issue(input int u, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3[u]   = f;
        rs1_data[u] = a;
        rs2_data[u] = b;
        rd_in[u]    = rd;
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
    endtask

    // Count edges (accept edge = 1) until out_valid, bounded.
    task automatic wait_done(input int u, output int lat);
        lat = 1;
        while (!out_valid[u] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire(input int u, input string name);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        chk({name, " post-ack out_valid"}, 32'(out_valid[u]), 32'd0);
        chk({name, " post-ack in_ready"}, 32'(in_ready[u]), 32'd1);
    endtask

    task automatic run_checked(input int u, input string name, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp,
                               input logic special);
        int lat;
        issue(u, f, a, b, rd);
        wait_done(u, lat);
        chk({name, " latency"}, 32'(lat), special ? 32'd1 : 32'(1 + XLEN / step_of(u)));
        chk({name, " result"}, result[u], exp);
        chk({name, " rd_out"}, 32'(rd_out[u]), 32'(rd));
        chk({name, " in_ready in DONE"}, 32'(in_ready[u]), 32'd0);
        retire(u, name);
    endtask

    task automatic no_valid_for(input int u, input string name, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[u]) seen++;
        end
        chk({name, " spurious out_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; in_valid[u] = 1'b0; funct3[u] = '0;
            rs1_data[u] = '0; rs2_data[u] = '0; rd_in[u] = '0;
            flush[u] = 1'b0; out_ready[u] = 1'b0;
        end

        //              f3      rs1           rs2           expected      special
        vec.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}); // MUL 7*-3
        vec.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}); // MULH
        vec.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}); // MULHU
        vec.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0}); // MUL
        vec.push_back('{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0}); // MUL
        vec.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0}); // MULHSU -1*2
        vec.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0}); // MULHSU
        vec.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}); // MULH -1*-1
        vec.push_back('{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}); // MULH 7*-3
        vec.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}); // DIV ovf
        vec.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}); // REM ovf
        vec.push_back('{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1}); // DIVU /0
        vec.push_back('{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1}); // REMU /0
        vec.push_back('{3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1}); // DIV /0
        vec.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1}); // REM -7/0
        vec.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0}); // REM -7/2
        vec.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0}); // DIV -7/2
        vec.push_back('{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0}); // DIV 7/-2
        vec.push_back('{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0}); // REM 7/-2
        vec.push_back('{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 1'b0}); // DIV -7/-2
        vec.push_back('{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0}); // REM -7/-2
        vec.push_back('{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0}); // DIVU 100/7
        vec.push_back('{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0}); // REMU 100/7
        vec.push_back('{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0}); // DIVU
        vec.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0}); // REMU
        vec.push_back('{3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0}); // DIV min/1
        vec.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0}); // DIVU
        vec.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0}); // REMU

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d reset in_ready", u), 32'(in_ready[u]), 32'd1);
            chk($sformatf("u%0d reset out_valid", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("u%0d reset busy", u), 32'(busy[u]), 32'd0);
            chk($sformatf("u%0d reset result", u), result[u], 32'd0);
            chk($sformatf("u%0d reset rd_out", u), 32'(rd_out[u]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int u = 0; u < 2; u++) begin
            // Table-driven vectors
            for (int i = 0; i < vec.size(); i++) begin
                run_checked(u, $sformatf("u%0d v%0d", u, i), vec[i].f3, vec[i].a,
                            vec[i].b, 5'(i + 3), vec[i].exp, vec[i].special);
            end

            // Hold result in DONE for 10 cycles with out_ready low
            begin
                int lat;
                issue(u, 3'b000, 32'h7, 32'hFFFFFFFD, 5'd9);
                wait_done(u, lat);
                chk($sformatf("u%0d hold latency", u), 32'(lat), 32'(1 + XLEN / step_of(u)));
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("u%0d hold%0d out_valid", u, c), 32'(out_valid[u]), 32'd1);
                    chk($sformatf("u%0d hold%0d result", u, c), result[u], 32'hFFFFFFEB);
                    chk($sformatf("u%0d hold%0d rd_out", u, c), 32'(rd_out[u]), 32'd9);
                    chk($sformatf("u%0d hold%0d in_ready", u, c), 32'(in_ready[u]), 32'd0);
                end
                // New op offered in the completing cycle must not be taken
                @(negedge clk);
                out_ready[u] = 1'b1;
                in_valid[u]  = 1'b1;
                funct3[u]    = 3'b000;
                rs1_data[u]  = 32'd2;
                rs2_data[u]  = 32'd3;
                @(posedge clk);
                #1;
                out_ready[u] = 1'b0;
                in_valid[u]  = 1'b0;
                chk($sformatf("u%0d overlap busy", u), 32'(busy[u]), 32'd0);
                chk($sformatf("u%0d overlap in_ready", u), 32'(in_ready[u]), 32'd1);
                no_valid_for(u, $sformatf("u%0d overlap", u), 40);
            end

            // Flush mid-CALC, then a fresh op completes normally
            begin
                int k = (u == 0) ? 10 : 3;
                issue(u, 3'b000, 32'd3, 32'd5, 5'd4);
                repeat (k - 1) @(posedge clk);
                @(negedge clk);
                chk($sformatf("u%0d calc busy", u), 32'(busy[u]), 32'd1);
                flush[u] = 1'b1;
                @(posedge clk);
                #1;
                flush[u] = 1'b0;
                chk($sformatf("u%0d flush out_valid", u), 32'(out_valid[u]), 32'd0);
                chk($sformatf("u%0d flush in_ready", u), 32'(in_ready[u]), 32'd1);
                chk($sformatf("u%0d flush busy", u), 32'(busy[u]), 32'd0);
                no_valid_for(u, $sformatf("u%0d flush", u), 40);
                run_checked(u, $sformatf("u%0d post-flush MULHU", u), 3'b011,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 1'b0);
            end

            // Flush together with out_ready in DONE: no handshake, back to IDLE
            begin
                int lat;
                issue(u, 3'b101, 32'd5, 32'd0, 5'd6);
                wait_done(u, lat);
                chk($sformatf("u%0d fdone latency", u), 32'(lat), 32'd1);
                @(negedge clk);
                flush[u]     = 1'b1;
                out_ready[u] = 1'b1;
                #1;
                chk($sformatf("u%0d fdone out_valid masked", u), 32'(out_valid[u]), 32'd0);
                @(posedge clk);
                #1;
                flush[u]     = 1'b0;
                out_ready[u] = 1'b0;
                chk($sformatf("u%0d fdone in_ready", u), 32'(in_ready[u]), 32'd1);
                chk($sformatf("u%0d fdone out_valid", u), 32'(out_valid[u]), 32'd0);
            end

            // Flush together with in_valid in IDLE: op not accepted
            @(negedge clk);
            in_valid[u] = 1'b1;
            flush[u]    = 1'b1;
            funct3[u]   = 3'b000;
            rs1_data[u] = 32'd4;
            rs2_data[u] = 32'd4;
            @(posedge clk);
            #1;
            in_valid[u] = 1'b0;
            flush[u]    = 1'b0;
            chk($sformatf("u%0d fidle busy", u), 32'(busy[u]), 32'd0);
            no_valid_for(u, $sformatf("u%0d fidle", u), 40);

            // Asynchronous reset mid-CALC
            issue(u, 3'b001, 32'h80000000, 32'h80000000, 5'd17);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst[u] = 1'b1;
            #1;
            chk($sformatf("u%0d arst in_ready", u), 32'(in_ready[u]), 32'd1);
            chk($sformatf("u%0d arst out_valid", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("u%0d arst busy", u), 32'(busy[u]), 32'd0);
            chk($sformatf("u%0d arst result", u), result[u], 32'd0);
            chk($sformatf("u%0d arst rd_out", u), 32'(rd_out[u]), 32'd0);
            @(negedge clk);
            rst[u] = 1'b0;
            run_checked(u, $sformatf("u%0d post-reset DIV", u), 3'b100,
                        32'hFFFFFFF9, 32'd2, 5'd21, 32'hFFFFFFFD, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
